pool_window_gen: RTL



---
 rtl/pool_window_gen_pkg.sv | 23 ++
 rtl/pool_window_gen_if.sv | 21 ++
 rtl/pool_window_gen_line_buffer.sv | 47 ++++
 rtl/pool_window_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pool_window_gen_pkg.sv
// Shared constants and helpers for the pooling window producer and the max pooling stage.
// Window packing: element (r,c) sits at bit offset (r*pool+c)*data, element (0,0) at the LSBs.
package pool_window_gen_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_POOL_SIZE = 2;

    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int win_offset(input int r, input int c, input int pool, input int data);
        return (r * pool + c) * data;
    endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in, packed window stream out; master is the upstream side, slave the window generator.
interface pool_window_gen_if import pool_window_gen_pkg::*; #(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int POOL_SIZE = DEF_POOL_SIZE
);
    logic                                       enable;
    logic [DATA_SIZE-1:0]                       pixel_in;
    logic [DATA_SIZE*POOL_SIZE*POOL_SIZE-1:0]   window_out;
    logic                                       window_valid;
    logic                                       frame_done;

    modport master (
        output enable, pixel_in,
        input  window_out, window_valid, frame_done
    );

    modport slave (
        input  enable, pixel_in,
        output window_out, window_valid, frame_done
    );
endinterface

// File: rtl/pool_window_gen_line_buffer.sv
// Line buffer for the upper pool_size-1 rows of a band: synchronous write, combinational read
// of pool_size adjacent columns from every stored row at once.
module pool_line_buffer import pool_window_gen_pkg::*; #(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int POOL_SIZE = DEF_POOL_SIZE,
    parameter int IMG_WIDTH = 8,
    parameter int CW        = 3,
    parameter int PW        = 1
) (
    input  logic                                        clk,
    input  logic                                        i_we,
    input  logic [PW-1:0]                               i_wrow,
    input  logic [CW-1:0]                               i_wcol,
    input  logic [DATA_SIZE-1:0]                        i_wdata,
    input  logic [CW-1:0]                               i_rcol,
    output logic [(POOL_SIZE-1)*POOL_SIZE*DATA_SIZE-1:0] o_rdata
);
    localparam int ROWS = POOL_SIZE - 1;

    logic [DATA_SIZE-1:0] r_mem [ROWS][IMG_WIDTH];

    // Store the incoming pixel at (band row, column); contents are never cleared.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < IMG_WIDTH; c++) begin
                if (i_we && (i_wrow == PW'(r)) && (i_wcol == CW'(c))) begin
                    r_mem[r][c] <= i_wdata;
                end
            end
        end
    end

    // One-hot column select per output word; out-of-range columns read as zero.
    always_comb begin
        o_rdata = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < POOL_SIZE; c++) begin
                for (int k = 0; k < IMG_WIDTH; k++) begin
                    o_rdata[win_offset(r, c, POOL_SIZE, DATA_SIZE) +: DATA_SIZE] =
                        o_rdata[win_offset(r, c, POOL_SIZE, DATA_SIZE) +: DATA_SIZE] |
                        (((int'(i_rcol) + c) == k) ? r_mem[r][k] : {DATA_SIZE{1'b0}});
                end
            end
        end
    end

endmodule

// File: rtl/pool_window_gen.sv
// Streaming non-overlapping pooling window generator: raster pixels in, packed pool_size^2 windows out.
// Partial trailing columns/rows are counted but never produce a window.
module pool_window_gen import pool_window_gen_pkg::*; #(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int POOL_SIZE  = DEF_POOL_SIZE,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic              clk,
    input  logic              reset,
    pool_window_gen_if.slave  bus
);
    localparam int CW    = clog2_min1(IMG_WIDTH);
    localparam int RW    = clog2_min1(IMG_HEIGHT);
    localparam int PW    = clog2_min1(POOL_SIZE);
    localparam int ROWS  = POOL_SIZE - 1;
    localparam int WIN_W = DATA_SIZE * POOL_SIZE * POOL_SIZE;

    logic [CW-1:0]                      r_col;
    logic [RW-1:0]                      r_row;
    logic [PW-1:0]                      r_cphase;
    logic [PW-1:0]                      r_rphase;
    logic [DATA_SIZE-1:0]               r_colsr [ROWS];
    logic [WIN_W-1:0]                   r_window;
    logic                               r_valid;
    logic                               r_frame_done;

    logic                               w_accept;
    logic                               w_fill;
    logic                               w_emit;
    logic                               w_col_last;
    logic                               w_row_last;
    logic [CW-1:0]                      w_rbase;
    logic [ROWS*POOL_SIZE*DATA_SIZE-1:0] w_lb_rd;
    logic [WIN_W-1:0]                   w_window;

    assign w_accept   = bus.enable && !reset;
    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_fill     = (r_rphase != PW'(POOL_SIZE - 1));
    assign w_emit     = w_accept && !w_fill && (r_cphase == PW'(POOL_SIZE - 1));
    assign w_rbase    = r_col - CW'(POOL_SIZE - 1);

    pool_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .POOL_SIZE (POOL_SIZE),
        .IMG_WIDTH (IMG_WIDTH),
        .CW        (CW),
        .PW        (PW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_accept && w_fill),
        .i_wrow  (r_rphase),
        .i_wcol  (r_col),
        .i_wdata (bus.pixel_in),
        .i_rcol  (w_rbase),
        .o_rdata (w_lb_rd)
    );

    // Raster position plus column/row phase within the current pool band.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_cphase <= '0;
            r_rphase <= '0;
        end else if (bus.enable) begin
            if (w_col_last) begin
                r_col    <= '0;
                r_cphase <= '0;
                if (w_row_last) begin
                    r_row    <= '0;
                    r_rphase <= '0;
                end else begin
                    r_row    <= r_row + RW'(1);
                    r_rphase <= (r_rphase == PW'(POOL_SIZE - 1)) ? '0 : r_rphase + PW'(1);
                end
            end else begin
                r_col    <= r_col + CW'(1);
                r_cphase <= (r_cphase == PW'(POOL_SIZE - 1)) ? '0 : r_cphase + PW'(1);
            end
        end
    end

    // Bottom-row pixels of the band; index 0 is the most recent one.
    always_ff @(posedge clk) begin
        if (w_accept && !w_fill) begin
            r_colsr[0] <= bus.pixel_in;
            for (int k = 1; k < ROWS; k++) begin
                r_colsr[k] <= r_colsr[k-1];
            end
        end
    end

    // Window assembly: stored rows on top, shift register plus live pixel on the bottom row.
    always_comb begin
        w_window = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < POOL_SIZE; c++) begin
                w_window[win_offset(r, c, POOL_SIZE, DATA_SIZE) +: DATA_SIZE] =
                    w_lb_rd[win_offset(r, c, POOL_SIZE, DATA_SIZE) +: DATA_SIZE];
            end
        end
        for (int c = 0; c < POOL_SIZE - 1; c++) begin
            w_window[win_offset(ROWS, c, POOL_SIZE, DATA_SIZE) +: DATA_SIZE] = r_colsr[POOL_SIZE-2-c];
        end
        w_window[win_offset(ROWS, ROWS, POOL_SIZE, DATA_SIZE) +: DATA_SIZE] = bus.pixel_in;
    end

    // Registered outputs; window_out holds its last value between windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_window     <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_emit;
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_emit) begin
                r_window <= w_window;
            end
        end
    end

    assign bus.window_out   = r_window;
    assign bus.window_valid = r_valid;
    assign bus.frame_done   = r_frame_done;

endmodule
